and2_in_cond: RTL and testbench

Two-channel input conditioner placed directly upstream of the registered 2-input AND stage. It synchronises asynchronous inputs `a_in`/`b_in` into `clk` and debounces each channel independently. It drives clean, glitch-free `a`/`b` levels into the AND stage. Optional per-channel edge pulses are available for event logging.

---
 rtl/and2_in_cond_pkg.sv | 18 +
 rtl/and2_in_cond_chan.sv | 129 ++++++++++++
 rtl/and2_in_cond.sv | 56 +++++
 tb/tb_and2_in_cond.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/and2_in_cond_pkg.sv
// Shared constants and types for the two-channel AND-stage input conditioner.
// Optional edge-pulse logic is enabled by defining AND2_IN_COND_EDGE_EN.
package and2_in_cond_pkg;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic {
      STABLE = 1'b0,
      PEND   = 1'b1
   } cond_state_t;

   // Counter must hold DEBOUNCE_CYCLES-1 without wrapping.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/and2_in_cond_chan.sv
// One conditioner channel: synchroniser chain, debounce counter/FSM, output flop.
// Edge pulse flops exist only when AND2_IN_COND_EDGE_EN is defined.
module and2_in_cond_chan
   import and2_in_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic busy,
   output logic rise,
   output logic fall
);

   localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   s_x;

   cond_state_t            state_reg;
   cond_state_t            state_next;
   logic [CW-1:0]          cnt_reg;
   logic [CW-1:0]          cnt_next;
   logic                   level_reg;
   logic                   level_next;
   logic                   confirm;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_next[gi] = raw;
         end else begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= sync_next;
      end
   end

   assign s_x = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= STABLE;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         level_reg <= level_next;
      end
   end

   // A change is confirmed on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      confirm    = 1'b0;
      case (state_reg)
         STABLE: begin
            cnt_next = '0;
            if (s_x != level_reg) begin
               if (CNT_MAX == '0) begin
                  confirm = 1'b1;
               end else begin
                  state_next = PEND;
                  cnt_next   = CNT_ONE;
               end
            end
         end
         PEND: begin
            if (s_x == level_reg) begin
               state_next = STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
               confirm    = 1'b1;
               state_next = STABLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = STABLE;
            cnt_next   = '0;
         end
      endcase
      level_next = level_reg ^ confirm;
   end

   assign level = level_reg;
   assign busy  = (cnt_reg != '0);

`ifdef AND2_IN_COND_EDGE_EN
   logic rise_reg;
   logic fall_reg;

   // Pulses land on the same edge as the output update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         rise_reg <= confirm & s_x;
         fall_reg <= confirm & ~s_x;
      end
   end

   assign rise = rise_reg;
   assign fall = fall_reg;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/and2_in_cond.sv
// Two-channel synchronise/debounce front end for the registered AND stage.
// Define AND2_IN_COND_EDGE_EN to enable the per-channel rise/fall pulses.
module and2_in_cond
   import and2_in_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic a_in,
   input  logic b_in,
   output logic a,
   output logic b,
   output logic busy,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall
);

   logic [1:0] raw;
   logic [1:0] level;
   logic [1:0] chan_busy;
   logic [1:0] rise;
   logic [1:0] fall;

   assign raw = {b_in, a_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         and2_in_cond_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[gi]),
            .level (level[gi]),
            .busy  (chan_busy[gi]),
            .rise  (rise[gi]),
            .fall  (fall[gi])
         );
      end
   endgenerate

   assign a      = level[0];
   assign b      = level[1];
   assign busy   = |chan_busy;
   assign a_rise = rise[0];
   assign a_fall = fall[0];
   assign b_rise = rise[1];
   assign b_fall = fall[1];

endmodule

// File: tb/tb_and2_in_cond.sv
// Scoreboard bench for and2_in_cond: default build plus a DEBOUNCE_CYCLES=1 instance
// sharing the same inputs. Edge expectations follow AND2_IN_COND_EDGE_EN.
module tb_and2_in_cond;

`ifdef AND2_IN_COND_EDGE_EN
   localparam logic E = 1'b1;
`else
   localparam logic E = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic a_in;
   logic b_in;

   logic a0, b0, busy0, ar0, af0, br0, bf0;
   logic a1, b1, busy1, ar1, af1, br1, bf1;

   always #5 clk = ~clk;

   and2_in_cond dut (
      .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
      .a(a0), .b(b0), .busy(busy0),
      .a_rise(ar0), .a_fall(af0), .b_rise(br0), .b_fall(bf0)
   );

   and2_in_cond #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
      .a(a1), .b(b1), .busy(busy1),
      .a_rise(ar1), .a_fall(af1), .b_rise(br1), .b_fall(bf1)
   );

   typedef struct {
      int         cyc;
      string      tag;
      bit         sel;
      logic [6:0] v;
   } sb_t;

   sb_t sb[$];
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got %b want %b", tag, cyc, obs, exp);
      end else begin
         $display("ok   %s cyc %0d: %b", tag, cyc, obs);
      end
   endtask

   // Order: {a, b, busy, a_rise, a_fall, b_rise, b_fall}
   function automatic logic [6:0] vec(input logic va, input logic vb, input logic vbusy,
                                      input logic var_, input logic vaf,
                                      input logic vbr, input logic vbf);
      return {va, vb, vbusy, var_, vaf, vbr, vbf};
   endfunction

   // rel = number of edges from now after which the value must hold
   task automatic exp_at(input int rel, input string tag, input bit sel, input logic [6:0] v);
      sb_t e;
      e.cyc = cyc + rel;
      e.tag = tag;
      e.sel = sel;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic score();
      int i;
      logic [6:0] obs;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            obs = sb[i].sel ? {a1, b1, busy1, ar1, af1, br1, bf1}
                            : {a0, b0, busy0, ar0, af0, br0, bf0};
            chk(sb[i].tag, {25'd0, obs}, {25'd0, sb[i].v});
            sb.delete(i);
         end else begin
            i++;
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         score();
      end
   endtask

   initial begin
      reset = 1'b0;
      a_in  = 1'b1;
      b_in  = 1'b1;

      // Reset held for 3 edges with inputs high: everything stays 0.
      for (int k = 1; k <= 3; k++) begin
         exp_at(k, "rst_hold", 1'b0, 7'd0);
         exp_at(k, "rst_hold_d1", 1'b1, 7'd0);
      end
      step(3);

      // Release: both channels rise after edge 6 (edge 3 for DEBOUNCE_CYCLES=1).
      reset = 1'b1;
      exp_at(2, "rel_idle", 1'b0, 7'd0);
      exp_at(3, "rel_busy", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(5, "rel_busy5", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(6, "rel_rise", 1'b0, vec(1, 1, 0, E, 0, E, 0));
      exp_at(7, "rel_hold", 1'b0, vec(1, 1, 0, 0, 0, 0, 0));
      exp_at(2, "rel_d1_idle", 1'b1, 7'd0);
      exp_at(3, "rel_d1_rise", 1'b1, vec(1, 1, 0, E, 0, E, 0));
      exp_at(4, "rel_d1_hold", 1'b1, vec(1, 1, 0, 0, 0, 0, 0));
      step(8);

      // Both fall together.
      a_in = 1'b0;
      b_in = 1'b0;
      exp_at(3, "fall_busy", 1'b0, vec(1, 1, 1, 0, 0, 0, 0));
      exp_at(6, "fall_both", 1'b0, vec(0, 0, 0, 0, E, 0, E));
      exp_at(3, "fall_d1", 1'b1, vec(0, 0, 0, 0, E, 0, E));
      exp_at(4, "fall_d1_hold", 1'b1, 7'd0);
      step(8);

      // Bounce reject: 3-sample pulse never reaches a on the default build.
      a_in = 1'b1;
      exp_at(3, "rej_busy", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(5, "rej_busy5", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(6, "rej_drop", 1'b0, 7'd0);
      exp_at(8, "rej_quiet", 1'b0, 7'd0);
      exp_at(3, "rej_d1_rise", 1'b1, vec(1, 0, 0, E, 0, 0, 0));
      exp_at(6, "rej_d1_fall", 1'b1, vec(0, 0, 0, 0, E, 0, 0));
      step(3);
      a_in = 1'b0;
      step(7);

      // Clean step on a.
      a_in = 1'b1;
      exp_at(2, "step_idle", 1'b0, 7'd0);
      exp_at(3, "step_busy", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(5, "step_pre", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(6, "step_rise", 1'b0, vec(1, 0, 0, E, 0, 0, 0));
      exp_at(7, "step_hold", 1'b0, vec(1, 0, 0, 0, 0, 0, 0));
      step(8);
      a_in = 1'b0;
      exp_at(6, "step_fall", 1'b0, vec(0, 0, 0, 0, E, 0, 0));
      step(8);

      // Bounce restart: high 3, low 1, then steady high.
      a_in = 1'b1;
      exp_at(5, "rst_cnt_busy", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(6, "rst_cnt_clear", 1'b0, 7'd0);
      exp_at(7, "rst_cnt_again", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(9, "rst_cnt_pre", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(10, "rst_cnt_rise", 1'b0, vec(1, 0, 0, E, 0, 0, 0));
      exp_at(11, "rst_cnt_hold", 1'b0, vec(1, 0, 0, 0, 0, 0, 0));
      step(3);
      a_in = 1'b0;
      step(1);
      a_in = 1'b1;
      step(9);
      a_in = 1'b0;
      exp_at(6, "rst_cnt_fall", 1'b0, vec(0, 0, 0, 0, E, 0, 0));
      step(8);

      // Simultaneous rise on both channels.
      a_in = 1'b1;
      b_in = 1'b1;
      exp_at(5, "sim_busy", 1'b0, vec(0, 0, 1, 0, 0, 0, 0));
      exp_at(6, "sim_rise", 1'b0, vec(1, 1, 0, E, 0, E, 0));
      exp_at(3, "sim_d1_rise", 1'b1, vec(1, 1, 0, E, 0, E, 0));
      step(8);

      // Reset while a's fall is pending: a clears with no fall pulse.
      a_in = 1'b0;
      exp_at(4, "mid_pend", 1'b0, vec(1, 1, 1, 0, 0, 0, 0));
      exp_at(5, "mid_rst", 1'b0, 7'd0);
      exp_at(6, "mid_rst2", 1'b0, 7'd0);
      exp_at(3, "mid_d1_fall", 1'b1, vec(0, 1, 0, 0, E, 0, 0));
      exp_at(5, "mid_d1_rst", 1'b1, 7'd0);
      step(4);
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(2);

      chk("sb_drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
